// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one bus transaction per core request, with byte-lane
// formatting, misalignment detection and a bounded wait for bus acknowledge.
module rv32i_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fRead,
  input  logic        i_fWrite,
  input  logic [1:0]  i_Size,
  input  logic        i_fSignEx,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_Data,
  output logic [31:0] o_Data,
  output logic        o_fStall,
  output logic        o_fMisalign,
  output logic        o_fBusErr,
  output logic        o_BusReq,
  output logic        o_BusWE,
  output logic [29:0] o_BusAddr,
  output logic [3:0]  o_BusBE,
  output logic [31:0] o_BusWData,
  input  logic        i_BusAck,
  input  logic [31:0] i_BusRData
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic            we_q;
  logic            req_q;
  logic            err_q;
  logic [29:0]     addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;

  logic            req_in;
  logic            mis_in;
  logic            accept;
  logic [3:0]      be_d;
  logic [31:0]     wdata_d;
  logic [31:0]     rdata_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_format(input logic [1:0] size, input logic [1:0] off,
                                              input logic sgn, input logic [31:0] rdata);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {off, 3'b000};
    case (size)
      2'b00:   r = {{24{sgn & s[7]}}, s[7:0]};
      2'b01:   r = {{16{sgn & s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign req_in  = i_fRead | i_fWrite;
  assign mis_in  = misaligned(i_Size, i_Addr[1:0]);
  assign accept  = (state_q == ST_IDLE) && req_in && !mis_in;
  assign be_d    = byte_en(i_Size, i_Addr[1:0]);
  assign wdata_d = store_lanes(i_Size, i_Data);
  assign rdata_d = load_format(size_q, off_q, sgn_q, i_BusRData);

  assign o_fMisalign = (state_q == ST_IDLE) && req_in && mis_in;
  assign o_fStall    = accept || (state_q == ST_BUSY);
  assign o_BusReq    = req_q;
  assign o_BusWE     = we_q;
  assign o_BusAddr   = addr_q;
  assign o_BusBE     = be_q;
  assign o_BusWData  = wdata_q;
  assign o_Data      = rdata_q;
  assign o_fBusErr   = err_q;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= '0;
            off_q   <= i_Addr[1:0];
            size_q  <= i_Size;
            sgn_q   <= i_fSignEx;
            we_q    <= i_fWrite;
            addr_q  <= i_Addr[31:2];
            be_q    <= be_d;
            wdata_q <= wdata_d;
            req_q   <= 1'b1;
          end
        end
        ST_BUSY: begin
          // An ack on the final counted cycle still completes normally.
          if (i_BusAck) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              rdata_q <= rdata_d;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Testbench for rv32i_lsu: directed scenarios plus randomized accesses checked
// against an arithmetic byte-lane model of loads, stores and bus timing.
module tb_rv32i_lsu;

  localparam int TMO = 16;

  logic        i_Clk;
  logic        i_Rst;
  logic        i_fRead;
  logic        i_fWrite;
  logic [1:0]  i_Size;
  logic        i_fSignEx;
  logic [31:0] i_Addr;
  logic [31:0] i_Data;
  logic [31:0] o_Data;
  logic        o_fStall;
  logic        o_fMisalign;
  logic        o_fBusErr;
  logic        o_BusReq;
  logic        o_BusWE;
  logic [29:0] o_BusAddr;
  logic [3:0]  o_BusBE;
  logic [31:0] o_BusWData;
  logic        i_BusAck;
  logic [31:0] i_BusRData;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_data;

  rv32i_lsu #(.TIMEOUT(TMO)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_fRead    (i_fRead),
    .i_fWrite   (i_fWrite),
    .i_Size     (i_Size),
    .i_fSignEx  (i_fSignEx),
    .i_Addr     (i_Addr),
    .i_Data     (i_Data),
    .o_Data     (o_Data),
    .o_fStall   (o_fStall),
    .o_fMisalign(o_fMisalign),
    .o_fBusErr  (o_fBusErr),
    .o_BusReq   (o_BusReq),
    .o_BusWE    (o_BusWE),
    .o_BusAddr  (o_BusAddr),
    .o_BusBE    (o_BusBE),
    .o_BusWData (o_BusWData),
    .i_BusAck   (i_BusAck),
    .i_BusRData (i_BusRData)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: bytes touched by an access of n bytes at offset off.
  function automatic logic [3:0] m_be(input int n, input int off);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] d);
    logic [31:0] w;
    longint      dd;
    dd = longint'(d);
    w  = '0;
    for (int i = 0; i < 4; i++)
      w = w | (32'((dd >> (8 * (i % n))) & 255) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int n, input int off, input bit sx,
                                         input logic [31:0] rd);
    longint v;
    longint span;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * off)) % span;
    if (sx && n < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One core request; ackd is the BUSY cycle index carrying ack (<0: never).
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdv, input int ackd);
    int n;
    int off;
    bit mis;
    bit tmo;
    bit we;
    n   = 1 << sz;
    off = int'(a % 4);
    mis = (sz == 2'b11) || ((a % n) != 0);
    tmo = (ackd < 0) || (ackd >= TMO);
    we  = wr;
    i_fRead   = rd;
    i_fWrite  = wr;
    i_Size    = sz;
    i_fSignEx = sx;
    i_Addr    = a;
    i_Data    = d;
    i_BusAck  = 1'b0;
    #1;
    chk1("idle_misalign", o_fMisalign, mis);
    chk1("idle_stall", o_fStall, !mis);
    if (mis) begin
      @(posedge i_Clk); #1;
      chk1("mis_no_busreq", o_BusReq, 1'b0);
      chk1("mis_stays_idle", o_fMisalign, 1'b1);
      i_fRead  = 1'b0;
      i_fWrite = 1'b0;
      return;
    end
    @(posedge i_Clk); #1;
    for (int k = 0; k < TMO + 2; k++) begin
      chk1("busy_req", o_BusReq, 1'b1);
      chk1("busy_stall", o_fStall, 1'b1);
      chk1("busy_we", o_BusWE, we);
      chk32("busy_addr", 32'(o_BusAddr), a >> 2);
      chk32("busy_be", 32'(o_BusBE), 32'(m_be(n, off)));
      if (we) chk32("busy_wdata", o_BusWData, m_wdata(n, d));
      i_BusRData = (k == ackd) ? rdv : $urandom;
      i_BusAck   = (k == ackd);
      @(posedge i_Clk); #1;
      if ((!tmo && k == ackd) || (tmo && k == TMO - 1)) break;
    end
    i_BusAck = 1'b0;
    if (tmo) exp_data = '0;
    else if (!we) exp_data = m_load(n, off, sx, rdv);
    chk1("done_req", o_BusReq, 1'b0);
    chk1("done_stall", o_fStall, 1'b0);
    chk1("done_buserr", o_fBusErr, tmo);
    chk32("done_data", o_Data, exp_data);
    i_fRead  = 1'b0;
    i_fWrite = 1'b0;
    @(posedge i_Clk); #1;
    chk1("post_buserr", o_fBusErr, 1'b0);
    chk1("post_req", o_BusReq, 1'b0);
    chk32("post_data", o_Data, exp_data);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    exp_data   = '0;
    i_Rst      = 1'b0;
    i_fRead    = 1'b0;
    i_fWrite   = 1'b0;
    i_Size     = 2'b00;
    i_fSignEx  = 1'b0;
    i_Addr     = '0;
    i_Data     = '0;
    i_BusAck   = 1'b0;
    i_BusRData = '0;
    #2;
    chk32("rst_data", o_Data, 32'h0);
    chk1("rst_req", o_BusReq, 1'b0);
    chk1("rst_we", o_BusWE, 1'b0);
    chk32("rst_be", 32'(o_BusBE), 32'h0);
    chk32("rst_addr", 32'(o_BusAddr), 32'h0);
    chk32("rst_wdata", o_BusWData, 32'h0);
    chk1("rst_buserr", o_fBusErr, 1'b0);
    chk1("rst_stall", o_fStall, 1'b0);
    @(posedge i_Clk); #1;
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;

    // Signed byte load from the top lane, ack on the second BUSY cycle.
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 1);
    chk32("byte_signed_const", o_Data, 32'hFFFF_FF80);

    // Reset in the second BUSY cycle, then a late ack after release.
    i_fRead = 1'b1; i_fWrite = 1'b0; i_Size = 2'b10; i_Addr = 32'h0000_0400;
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #1;
    chk1("mid_busy_req", o_BusReq, 1'b1);
    i_fRead = 1'b0;
    i_Rst   = 1'b0;
    exp_data = '0;
    #1;
    chk1("arst_req", o_BusReq, 1'b0);
    chk32("arst_data", o_Data, 32'h0);
    chk32("arst_be", 32'(o_BusBE), 32'h0);
    chk32("arst_addr", 32'(o_BusAddr), 32'h0);
    chk1("arst_stall", o_fStall, 1'b0);
    @(posedge i_Clk); #1;
    i_Rst    = 1'b1;
    i_BusAck = 1'b1;
    @(posedge i_Clk); #1;
    chk1("late_ack_req", o_BusReq, 1'b0);
    @(posedge i_Clk); #1;
    chk1("late_ack_req2", o_BusReq, 1'b0);
    chk1("late_ack_stall", o_fStall, 1'b0);
    chk32("late_ack_data", o_Data, 32'h0);
    i_BusAck = 1'b0;

    // Half store into the upper half, immediate ack.
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
    chk32("half_store_data_kept", o_Data, 32'h0);

    // Misaligned word and illegal size.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);

    // Read and write together is a write.
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h1111_2222, 2);

    // Load some nonzero data, then a word read that never sees ack.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h5A5A_1234, 0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h0, -1);
    i_BusAck = 1'b1;
    @(posedge i_Clk); #1;
    chk1("stray_ack_req", o_BusReq, 1'b0);
    chk1("stray_ack_stall", o_fStall, 1'b0);
    chk32("stray_ack_data", o_Data, 32'h0);
    i_BusAck = 1'b0;

    for (int t = 0; t < 40; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          kind;
      int          ackd;
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      kind = $urandom_range(0, 2);
      ackd = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) ackd = -1;
      access(kind != 1, kind != 0, sz, 1'($urandom), a, $urandom, $urandom, ackd);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge i_Clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
